// File: rtl/key_input_conditioner.sv
// rtl/key_input_conditioner.sv - synchronise, debounce and arbitrate four pushbuttons into one-hot press pulses
module key_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] key_raw,
  input  logic       enable,
  output logic [3:0] key_pulse,
  output logic [3:0] key_held,
  output logic       any_held
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ARMED        = 2'd0;
  localparam logic [1:0] EMIT         = 2'd1;
  localparam logic [1:0] WAIT_RELEASE = 2'd2;

  logic [3:0]    pressed_raw;
  logic [3:0]    sync_meta;
  logic [3:0]    sync_key;
  logic [CW-1:0] cnt [4];
  logic [1:0]    state;
  logic [3:0]    lowest_held;

  // Normalise polarity so that 1 always means pressed from here on.
  assign pressed_raw = KEY_ACTIVE_LOW ? ~key_raw : key_raw;

  assign any_held = |key_held;

  // Two-flop synchroniser; only sync_meta may go metastable. Reset to released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_meta <= 4'b0000;
      sync_key  <= 4'b0000;
    end else begin
      sync_meta <= pressed_raw;
      sync_key  <= sync_meta;
    end
  end

  // Per-key debouncer: a new level is accepted only after it has held for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the held level restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      key_held <= 4'b0000;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_key[i] == key_held[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          key_held[i] <= sync_key[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Priority pick of the lowest-index held key (KEY0 wins).
  always_comb begin
    lowest_held = 4'b0000;
    if (key_held[0])      lowest_held = 4'b0001;
    else if (key_held[1]) lowest_held = 4'b0010;
    else if (key_held[2]) lowest_held = 4'b0100;
    else if (key_held[3]) lowest_held = 4'b1000;
  end

  // Arbiter: one pulse per press, swallowed when disabled, re-armed only when all keys are up.
  // key_pulse is a flop loaded on the ARMED->EMIT edge so it is glitch-free and one-hot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ARMED;
      key_pulse <= 4'b0000;
    end else begin
      key_pulse <= 4'b0000;
      case (state)
        ARMED: begin
          if (any_held) begin
            if (enable) begin
              state     <= EMIT;
              key_pulse <= lowest_held;
            end else begin
              state <= WAIT_RELEASE;
            end
          end
        end
        EMIT: begin
          state <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (!any_held) state <= ARMED;
        end
        default: begin
          state <= ARMED;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_input_conditioner.sv
// tb/tb_key_input_conditioner.sv - directed self-checking bench for key_input_conditioner
module tb_key_input_conditioner;

  logic       clock;
  logic       reset;
  logic [3:0] key_raw;
  logic       enable;
  logic [3:0] key_pulse;
  logic [3:0] key_held;
  logic       any_held;

  int n_checks = 0;
  int n_fail   = 0;

  key_input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .key_raw  (key_raw),
    .enable   (enable),
    .key_pulse(key_pulse),
    .key_held (key_held),
    .any_held (any_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    key_raw = 4'b1111;
    enable  = 1'b1;
    settle(3);
    n_checks++;
    if (key_pulse !== 4'b0000 || key_held !== 4'b0000 || any_held !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pulse=%b held=%b any=%b required 0000/0000/0", key_pulse, key_held, any_held);
    end
    reset = 1'b0;
    settle(8);
    n_checks++;
    if (key_pulse !== 4'b0000 || key_held !== 4'b0000) begin
      n_fail++;
      $display("FAIL idle_after_reset: pulse=%b held=%b required 0000/0000", key_pulse, key_held);
    end
  endtask

  task automatic test_clean_press();
    key_raw = 4'b1101;
    for (int e = 1; e <= 20; e++) begin
      tick();
      if (e == 5) begin
        n_checks++;
        if (key_held !== 4'b0000) begin
          n_fail++;
          $display("FAIL clean_held_early e=%0d: held=%b required 0000", e, key_held);
        end
      end
      if (e == 6) begin
        n_checks++;
        if (key_held !== 4'b0010 || any_held !== 1'b1) begin
          n_fail++;
          $display("FAIL clean_held e=%0d: held=%b any=%b required 0010/1", e, key_held, any_held);
        end
      end
      n_checks++;
      if (key_pulse !== ((e == 7) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL clean_pulse e=%0d: pulse=%b required %b", e, key_pulse, (e == 7) ? 4'b0010 : 4'b0000);
      end
    end
    key_raw = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++;
      if (key_pulse !== 4'b0000) begin
        n_fail++;
        $display("FAIL clean_release_pulse e=%0d: pulse=%b required 0000", e, key_pulse);
      end
    end
    n_checks++;
    if (key_held !== 4'b0000 || any_held !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_released: held=%b any=%b required 0000/0", key_held, any_held);
    end
  endtask

  task automatic test_bounce();
    for (int c = 0; c < 18; c++) begin
      key_raw = (c < 12 && ((c / 2) % 2 == 0)) ? 4'b1110 : 4'b1111;
      tick();
      n_checks++;
      if (key_held !== 4'b0000 || key_pulse !== 4'b0000) begin
        n_fail++;
        $display("FAIL bounce_quiet c=%0d: held=%b pulse=%b required 0000/0000", c, key_held, key_pulse);
      end
    end
    key_raw = 4'b1110;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++;
      if (key_pulse !== ((e == 7) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL bounce_hold_pulse e=%0d: pulse=%b required %b", e, key_pulse, (e == 7) ? 4'b0001 : 4'b0000);
      end
    end
    key_raw = 4'b1111;
    settle(10);
  endtask

  task automatic test_simultaneous();
    key_raw = 4'b0011;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 6) begin
        n_checks++;
        if (key_held !== 4'b1100) begin
          n_fail++;
          $display("FAIL simul_held: held=%b required 1100", key_held);
        end
      end
      n_checks++;
      if (key_pulse !== ((e == 7) ? 4'b0100 : 4'b0000)) begin
        n_fail++;
        $display("FAIL simul_pulse e=%0d: pulse=%b required %b", e, key_pulse, (e == 7) ? 4'b0100 : 4'b0000);
      end
    end
    key_raw = 4'b0111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++;
      if (key_pulse !== 4'b0000) begin
        n_fail++;
        $display("FAIL simul_partial_release e=%0d: pulse=%b required 0000", e, key_pulse);
      end
    end
    n_checks++;
    if (key_held !== 4'b1000) begin
      n_fail++;
      $display("FAIL simul_key3_still_held: held=%b required 1000", key_held);
    end
    key_raw = 4'b1111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++;
      if (key_pulse !== 4'b0000) begin
        n_fail++;
        $display("FAIL simul_full_release e=%0d: pulse=%b required 0000", e, key_pulse);
      end
    end
    key_raw = 4'b0111;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++;
      if (key_pulse !== ((e == 7) ? 4'b1000 : 4'b0000)) begin
        n_fail++;
        $display("FAIL simul_key3_pulse e=%0d: pulse=%b required %b", e, key_pulse, (e == 7) ? 4'b1000 : 4'b0000);
      end
    end
    key_raw = 4'b1111;
    settle(10);
  endtask

  task automatic test_enable_gating();
    enable  = 1'b0;
    key_raw = 4'b1101;
    for (int e = 1; e <= 20; e++) begin
      if (e == 11) enable = 1'b1;
      tick();
      n_checks++;
      if (key_pulse !== 4'b0000) begin
        n_fail++;
        $display("FAIL enable_swallow e=%0d: pulse=%b required 0000", e, key_pulse);
      end
    end
    n_checks++;
    if (key_held !== 4'b0010) begin
      n_fail++;
      $display("FAIL enable_held: held=%b required 0010", key_held);
    end
    key_raw = 4'b1111;
    settle(10);
    key_raw = 4'b1101;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++;
      if (key_pulse !== ((e == 7) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL enable_repress_pulse e=%0d: pulse=%b required %b", e, key_pulse, (e == 7) ? 4'b0010 : 4'b0000);
      end
    end
    key_raw = 4'b1111;
    settle(10);
  endtask

  task automatic test_reset_mid_press();
    key_raw = 4'b1110;
    settle(12);
    n_checks++;
    if (key_held !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_pre_held: held=%b required 0001", key_held);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (key_pulse !== 4'b0000 || key_held !== 4'b0000 || any_held !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async_clear: pulse=%b held=%b any=%b required 0000/0000/0", key_pulse, key_held, any_held);
    end
    settle(2);
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 5 || e == 6) begin
        n_checks++;
        if (key_held !== ((e == 6) ? 4'b0001 : 4'b0000)) begin
          n_fail++;
          $display("FAIL midreset_held e=%0d: held=%b required %b", e, key_held, (e == 6) ? 4'b0001 : 4'b0000);
        end
      end
      n_checks++;
      if (key_pulse !== ((e == 7) ? 4'b0001 : 4'b0000)) begin
        n_fail++;
        $display("FAIL midreset_pulse e=%0d: pulse=%b required %b", e, key_pulse, (e == 7) ? 4'b0001 : 4'b0000);
      end
    end
    key_raw = 4'b1111;
    settle(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_enable_gating();
    test_reset_mid_press();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
